// File: rtl/tlb_if.sv
// WB-stage TLB port bundle: fetch/data search ports, INVTLB request, TLBWR/TLBFILL write and TLBRD read.
interface tlb_if #(parameter int LOG2TLBNUM = 4);
  logic [18:0]           s0_vppn;
  logic                  s0_va_bit12;
  logic [9:0]            s0_asid;
  logic                  s0_found;
  logic [LOG2TLBNUM-1:0] s0_index;
  logic [19:0]           s0_ppn;
  logic [5:0]            s0_ps;
  logic [1:0]            s0_plv, s0_mat;
  logic                  s0_d, s0_v;

  logic [18:0]           s1_vppn;
  logic                  s1_va_bit12;
  logic [9:0]            s1_asid;
  logic                  s1_found;
  logic [LOG2TLBNUM-1:0] s1_index;
  logic [19:0]           s1_ppn;
  logic [5:0]            s1_ps;
  logic [1:0]            s1_plv, s1_mat;
  logic                  s1_d, s1_v;

  logic                  invtlb_valid;
  logic [4:0]            invtlb_op;

  logic                  we;
  logic [LOG2TLBNUM-1:0] w_index;
  logic                  w_e, w_g;
  logic [18:0]           w_vppn;
  logic [5:0]            w_ps;
  logic [9:0]            w_asid;
  logic [19:0]           w_ppn0, w_ppn1;
  logic [1:0]            w_plv0, w_mat0, w_plv1, w_mat1;
  logic                  w_d0, w_v0, w_d1, w_v1;

  logic [LOG2TLBNUM-1:0] r_index;
  logic                  r_e, r_g;
  logic [18:0]           r_vppn;
  logic [5:0]            r_ps;
  logic [9:0]            r_asid;
  logic [19:0]           r_ppn0, r_ppn1;
  logic [1:0]            r_plv0, r_mat0, r_plv1, r_mat1;
  logic                  r_d0, r_v0, r_d1, r_v1;

  modport master (
    output s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
           invtlb_valid, invtlb_op,
           we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
           w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
           r_index,
    input  s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
           s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
           r_e, r_vppn, r_ps, r_asid, r_g,
           r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1
  );

  modport slave (
    input  s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
           invtlb_valid, invtlb_op,
           we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
           w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
           r_index,
    output s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
           s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
           r_e, r_vppn, r_ps, r_asid, r_g,
           r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1
  );
endinterface

// File: rtl/tlb_array.sv
// Fully associative LoongArch TLB: two combinational search ports, TLBRD read,
// TLBWR/TLBFILL write and edge-triggered INVTLB invalidation.

// Page-size-aware VPPN compare; 4 KiB pages compare all 19 bits, 2 MiB pages only [18:9].
module tlb_va_cmp (
  input  logic [18:0] vppn,
  input  logic [5:0]  ps,
  input  logic [18:0] s_vppn,
  output logic        vmatch
);
  assign vmatch = (ps == 6'd12) ? (vppn == s_vppn) : (vppn[18:9] == s_vppn[18:9]);
endmodule

module tlb_array #(
  parameter int TLBNUM     = 16,
  parameter int LOG2TLBNUM = 4
) (
  input  logic clk,
  input  logic reset,
  tlb_if.slave bus
);
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    page_t       p0;
    page_t       p1;
  } ent_t;

  typedef struct packed {
    logic                  found;
    logic [LOG2TLBNUM-1:0] index;
    logic [19:0]           ppn;
    logic [5:0]            ps;
    logic [1:0]            plv;
    logic [1:0]            mat;
    logic                  d;
    logic                  v;
  } sres_t;

  ent_t [TLBNUM-1:0]  ent;
  ent_t               w_ent;
  logic [TLBNUM-1:0]  vm0, vm1, hit0, hit1, asid_eq1, inv_hit;
  sres_t              res0, res1;

  genvar gi;
  generate
    for (gi = 0; gi < TLBNUM; gi++) begin : g_ent
      tlb_va_cmp u_cmp0 (.vppn(ent[gi].vppn), .ps(ent[gi].ps), .s_vppn(bus.s0_vppn), .vmatch(vm0[gi]));
      tlb_va_cmp u_cmp1 (.vppn(ent[gi].vppn), .ps(ent[gi].ps), .s_vppn(bus.s1_vppn), .vmatch(vm1[gi]));
      assign asid_eq1[gi] = (ent[gi].asid == bus.s1_asid);
      assign hit0[gi] = ent[gi].e & (ent[gi].g | (ent[gi].asid == bus.s0_asid)) & vm0[gi];
      assign hit1[gi] = ent[gi].e & (ent[gi].g | asid_eq1[gi]) & vm1[gi];
    end
  endgenerate

  // Scan high-to-low so the lowest matching index is the last one written.
  function automatic sres_t lookup(input logic [TLBNUM-1:0] hit, input logic bit12,
                                   input logic bit8, input ent_t [TLBNUM-1:0] t);
    sres_t r;
    page_t pg;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pg      = ((t[i].ps == 6'd12) ? bit12 : bit8) ? t[i].p1 : t[i].p0;
        r.found = 1'b1;
        r.index = i[LOG2TLBNUM-1:0];
        r.ppn   = pg.ppn;
        r.ps    = t[i].ps;
        r.plv   = pg.plv;
        r.mat   = pg.mat;
        r.d     = pg.d;
        r.v     = pg.v;
      end
    end
    return r;
  endfunction

  assign res0 = lookup(hit0, bus.s0_va_bit12, bus.s0_vppn[8], ent);
  assign res1 = lookup(hit1, bus.s1_va_bit12, bus.s1_vppn[8], ent);

  assign {bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_ps,
          bus.s0_plv, bus.s0_mat, bus.s0_d, bus.s0_v} = res0;
  assign {bus.s1_found, bus.s1_index, bus.s1_ppn, bus.s1_ps,
          bus.s1_plv, bus.s1_mat, bus.s1_d, bus.s1_v} = res1;

  assign {bus.r_e, bus.r_vppn, bus.r_ps, bus.r_asid, bus.r_g,
          bus.r_ppn0, bus.r_plv0, bus.r_mat0, bus.r_d0, bus.r_v0,
          bus.r_ppn1, bus.r_plv1, bus.r_mat1, bus.r_d1, bus.r_v1} = ent[bus.r_index];

  assign w_ent = {bus.w_e, bus.w_vppn, bus.w_ps, bus.w_asid, bus.w_g,
                  bus.w_ppn0, bus.w_plv0, bus.w_mat0, bus.w_d0, bus.w_v0,
                  bus.w_ppn1, bus.w_plv1, bus.w_mat1, bus.w_d1, bus.w_v1};

  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (bus.invtlb_op)
        5'd0, 5'd1: inv_hit[i] = 1'b1;
        5'd2:       inv_hit[i] = ent[i].g;
        5'd3:       inv_hit[i] = ~ent[i].g;
        5'd4:       inv_hit[i] = ~ent[i].g & asid_eq1[i];
        5'd5:       inv_hit[i] = ~ent[i].g & asid_eq1[i] & vm1[i];
        5'd6:       inv_hit[i] = (ent[i].g | asid_eq1[i]) & vm1[i];
        default:    inv_hit[i] = 1'b0;
      endcase
    end
  end

  // The write follows the invalidation in this block so it overrides e on the same slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++)
        if (bus.invtlb_valid && inv_hit[i]) ent[i].e <= 1'b0;
      if (bus.we) ent[bus.w_index] <= w_ent;
    end
  end
endmodule

// File: tb/tb_tlb_array.sv
// Directed bench for tlb_array: reset, 4K/2M search, priority, INVTLB ops, write+INVTLB collision, async reset.
module tb_tlb_array;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] ev;

  tlb_if #(.LOG2TLBNUM(4)) bus();
  tlb_array #(.TLBNUM(16), .LOG2TLBNUM(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  wire [88:0] rd_all = {bus.r_e, bus.r_vppn, bus.r_ps, bus.r_asid, bus.r_g,
                        bus.r_ppn0, bus.r_plv0, bus.r_mat0, bus.r_d0, bus.r_v0,
                        bus.r_ppn1, bus.r_plv1, bus.r_mat1, bus.r_d1, bus.r_v1};

  task automatic set_w(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                       input logic [5:0] ps, input logic [9:0] asid, input logic g,
                       input logic [19:0] ppn0, input logic v0, input logic [19:0] ppn1, input logic v1);
    bus.w_index = idx; bus.w_e = e; bus.w_vppn = vppn; bus.w_ps = ps; bus.w_asid = asid; bus.w_g = g;
    bus.w_ppn0 = ppn0; bus.w_plv0 = 2'd0; bus.w_mat0 = 2'd1; bus.w_d0 = v0; bus.w_v0 = v0;
    bus.w_ppn1 = ppn1; bus.w_plv1 = 2'd3; bus.w_mat1 = 2'd1; bus.w_d1 = v1; bus.w_v1 = v1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                    input logic [5:0] ps, input logic [9:0] asid, input logic g,
                    input logic [19:0] ppn0, input logic v0, input logic [19:0] ppn1, input logic v1);
    @(negedge clk);
    set_w(idx, e, vppn, ps, asid, g, ppn0, v0, ppn1, v1);
    bus.we = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    @(negedge clk);
    bus.invtlb_valid = 1'b1; bus.invtlb_op = op; bus.s1_asid = asid; bus.s1_vppn = vppn;
    @(posedge clk); #1;
    bus.invtlb_valid = 1'b0;
  endtask

  task automatic get_ev(output logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      bus.r_index = i[3:0]; #1;
      v[i] = bus.r_e;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    for (int i = 0; i < 16; i++) begin
      bus.r_index = i[3:0]; #1;
      n_cmp++;
      if (rd_all !== 89'd0) begin n_err++; $display("FAIL reset_read[%0d]: got %h expected 0", i, rd_all); end
    end
    bus.s0_vppn = 19'h0; bus.s0_asid = 10'h0; bus.s1_vppn = 19'h7FFFF; bus.s1_asid = 10'h3FF; #1;
    n_cmp++;
    if ({bus.s0_found, bus.s1_found} !== 2'b00) begin
      n_err++; $display("FAIL reset_found: got %b expected 00", {bus.s0_found, bus.s1_found});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_4k_page;
    wr(4'd5, 1'b1, 19'h12345, 6'd12, 10'h3, 1'b0, 20'h0, 1'b0, 20'hABCDE, 1'b1);
    bus.s0_vppn = 19'h12345; bus.s0_va_bit12 = 1'b1; bus.s0_asid = 10'h3; #1;
    n_cmp++;
    if ({bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_v} !== {1'b1, 4'd5, 20'hABCDE, 1'b1}) begin
      n_err++; $display("FAIL 4k_odd_hit: got %b/%0d/%h/%b expected 1/5/abcde/1",
                        bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_v);
    end
    n_cmp++;
    if ({bus.s0_ps, bus.s0_plv, bus.s0_mat, bus.s0_d} !== {6'd12, 2'd3, 2'd1, 1'b1}) begin
      n_err++; $display("FAIL 4k_odd_attr: got ps=%0d plv=%0d mat=%0d d=%b expected 12/3/1/1",
                        bus.s0_ps, bus.s0_plv, bus.s0_mat, bus.s0_d);
    end
    bus.s0_va_bit12 = 1'b0; #1;
    n_cmp++;
    if ({bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_v} !== {1'b1, 4'd5, 20'h0, 1'b0}) begin
      n_err++; $display("FAIL 4k_even_sel: got %b/%0d/%h/%b expected 1/5/00000/0",
                        bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_v);
    end
    bus.s0_va_bit12 = 1'b1; bus.s0_asid = 10'h4; #1;
    n_cmp++;
    if ({bus.s0_found, bus.s0_index, bus.s0_ppn, bus.s0_ps, bus.s0_v} !== 32'd0) begin
      n_err++; $display("FAIL 4k_asid_miss: got %b/%0d/%h expected 0/0/00000",
                        bus.s0_found, bus.s0_index, bus.s0_ppn);
    end
    bus.r_index = 4'd5; #1;
    n_cmp++;
    if ({bus.r_e, bus.r_vppn, bus.r_asid, bus.r_g, bus.r_ppn1} !== {1'b1, 19'h12345, 10'h3, 1'b0, 20'hABCDE}) begin
      n_err++; $display("FAIL read_idx5: got e=%b vppn=%h asid=%h g=%b ppn1=%h expected 1/12345/003/0/abcde",
                        bus.r_e, bus.r_vppn, bus.r_asid, bus.r_g, bus.r_ppn1);
    end
  endtask

  task automatic test_huge_page;
    wr(4'd2, 1'b1, 19'h40000, 6'd21, 10'h7, 1'b1, 20'h111, 1'b1, 20'h222, 1'b1);
    bus.s1_vppn = 19'h400FF; bus.s1_va_bit12 = 1'b1; bus.s1_asid = 10'h155; #1;
    n_cmp++;
    if ({bus.s1_found, bus.s1_index, bus.s1_ppn} !== {1'b1, 4'd2, 20'h111}) begin
      n_err++; $display("FAIL 2m_even: got %b/%0d/%h expected 1/2/00111", bus.s1_found, bus.s1_index, bus.s1_ppn);
    end
    bus.s1_vppn = 19'h401FF; #1;
    n_cmp++;
    if ({bus.s1_found, bus.s1_index, bus.s1_ppn} !== {1'b1, 4'd2, 20'h222}) begin
      n_err++; $display("FAIL 2m_odd: got %b/%0d/%h expected 1/2/00222", bus.s1_found, bus.s1_index, bus.s1_ppn);
    end
    bus.s1_vppn = 19'h40200; #1;
    n_cmp++;
    if (bus.s1_found !== 1'b0) begin
      n_err++; $display("FAIL 2m_miss: got %b expected 0", bus.s1_found);
    end
    bus.s1_vppn = 19'h40000; bus.s1_asid = 10'h0; #1;
    n_cmp++;
    if ({bus.s1_found, bus.s1_index, bus.s1_ps} !== {1'b1, 4'd2, 6'd21}) begin
      n_err++; $display("FAIL 2m_base: got %b/%0d/%0d expected 1/2/21", bus.s1_found, bus.s1_index, bus.s1_ps);
    end
  endtask

  task automatic test_priority;
    wr(4'd9, 1'b1, 19'h0ABCD, 6'd12, 10'h0, 1'b1, 20'h99999, 1'b1, 20'h0, 1'b0);
    wr(4'd1, 1'b1, 19'h0ABCD, 6'd12, 10'h0, 1'b1, 20'h11111, 1'b1, 20'h0, 1'b0);
    bus.s0_vppn = 19'h0ABCD; bus.s0_va_bit12 = 1'b0; bus.s0_asid = 10'h3FF; #1;
    n_cmp++;
    if ({bus.s0_found, bus.s0_index, bus.s0_ppn} !== {1'b1, 4'd1, 20'h11111}) begin
      n_err++; $display("FAIL prio_low: got %b/%0d/%h expected 1/1/11111", bus.s0_found, bus.s0_index, bus.s0_ppn);
    end
    wr(4'd1, 1'b0, 19'h0ABCD, 6'd12, 10'h0, 1'b1, 20'h11111, 1'b1, 20'h0, 1'b0);
    n_cmp++;
    if ({bus.s0_found, bus.s0_index, bus.s0_ppn} !== {1'b1, 4'd9, 20'h99999}) begin
      n_err++; $display("FAIL prio_next: got %b/%0d/%h expected 1/9/99999", bus.s0_found, bus.s0_index, bus.s0_ppn);
    end
  endtask

  task automatic test_invtlb;
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0224) begin n_err++; $display("FAIL inv_pre: got %h expected 0224", ev); end
    inv(5'd4, 10'h3, 19'h0);
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0204) begin n_err++; $display("FAIL inv_op4: got %h expected 0204", ev); end
    bus.r_index = 4'd5; #1;
    n_cmp++;
    if ({bus.r_vppn, bus.r_asid, bus.r_ppn1} !== {19'h12345, 10'h3, 20'hABCDE}) begin
      n_err++; $display("FAIL inv_keep_fields: got %h/%h/%h expected 12345/003/abcde", bus.r_vppn, bus.r_asid, bus.r_ppn1);
    end
    inv(5'd2, 10'h0, 19'h0);
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0000) begin n_err++; $display("FAIL inv_op2: got %h expected 0000", ev); end
    wr(4'd5, 1'b1, 19'h12345, 6'd12, 10'h3, 1'b0, 20'h0, 1'b0, 20'hABCDE, 1'b1);
    wr(4'd2, 1'b1, 19'h40000, 6'd21, 10'h7, 1'b1, 20'h111, 1'b1, 20'h222, 1'b1);
    inv(5'd7, 10'h3, 19'h12345);
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0024) begin n_err++; $display("FAIL inv_op7: got %h expected 0024", ev); end
    inv(5'd5, 10'h3, 19'h12346);
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0024) begin n_err++; $display("FAIL inv_op5_miss: got %h expected 0024", ev); end
    inv(5'd5, 10'h3, 19'h12345);
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0004) begin n_err++; $display("FAIL inv_op5_hit: got %h expected 0004", ev); end
    inv(5'd6, 10'h0, 19'h400FF);
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0000) begin n_err++; $display("FAIL inv_op6: got %h expected 0000", ev); end
  endtask

  task automatic test_back_to_back;
    wr(4'd3, 1'b1, 19'h00100, 6'd12, 10'h1, 1'b1, 20'h3, 1'b1, 20'h0, 1'b0);
    wr(4'd7, 1'b1, 19'h00200, 6'd12, 10'h3, 1'b0, 20'h7, 1'b1, 20'h0, 1'b0);
    @(negedge clk);
    set_w(4'd5, 1'b1, 19'h00777, 6'd12, 10'h3, 1'b0, 20'h5, 1'b1, 20'h0, 1'b0);
    bus.we = 1'b1; bus.invtlb_valid = 1'b1; bus.invtlb_op = 5'd0;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.invtlb_valid = 1'b0;
    get_ev(ev);
    n_cmp++;
    if (ev !== 16'h0020) begin n_err++; $display("FAIL wr_inv_same_cycle: got %h expected 0020", ev); end
    @(posedge clk); #2;
    bus.s0_vppn = 19'h00777; bus.s0_va_bit12 = 1'b0; bus.s0_asid = 10'h3; #1;
    n_cmp++;
    if ({bus.s0_found, bus.s0_index, bus.s0_ppn} !== {1'b1, 4'd5, 20'h5}) begin
      n_err++; $display("FAIL pre_reset_hit: got %b/%0d/%h expected 1/5/00005", bus.s0_found, bus.s0_index, bus.s0_ppn);
    end
    reset = 1'b1; #1;
    n_cmp++;
    if (bus.s0_found !== 1'b0) begin n_err++; $display("FAIL async_reset_found: got %b expected 0", bus.s0_found); end
    bus.r_index = 4'd5; #1;
    n_cmp++;
    if (rd_all !== 89'd0) begin n_err++; $display("FAIL async_reset_read: got %h expected 0", rd_all); end
    @(negedge clk);
    set_w(4'd5, 1'b1, 19'h00777, 6'd12, 10'h3, 1'b0, 20'h5, 1'b1, 20'h0, 1'b0);
    bus.we = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
    n_cmp++;
    if (bus.r_e !== 1'b0) begin n_err++; $display("FAIL reset_over_write: got %b expected 0", bus.r_e); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.s0_vppn = '0; bus.s0_va_bit12 = 1'b0; bus.s0_asid = '0;
    bus.s1_vppn = '0; bus.s1_va_bit12 = 1'b0; bus.s1_asid = '0;
    bus.invtlb_valid = 1'b0; bus.invtlb_op = '0; bus.we = 1'b0; bus.r_index = '0;
    set_w(4'd0, 1'b0, 19'h0, 6'd0, 10'h0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
    test_reset;
    test_4k_page;
    test_huge_page;
    test_priority;
    test_invtlb;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tlb_array.md
Name: tlb_array

Overview:
- Fully associative 16-entry LoongArch TLB.
- Acts as the responder for the WB-stage TLB read/write/fill port.
- Also serves two combinational search ports: s0 for instruction fetch and s1 for load/store address translation and INVTLB.
- Holds all entry state. INVTLB invalidation executes on the clock edge.

Parameters:
TLBNUM, 16, number of entries
LOG2TLBNUM, 4, index width; must equal log2(TLBNUM)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all entries
s0_vppn  in  19  fetch VA[31:13]
s0_va_bit12  in  1  fetch VA[12]
s0_asid  in  10  current ASID
s0_found  out  1  hit
s0_index  out  LOG2TLBNUM  hit entry index
s0_ppn/s0_ps/s0_plv/s0_mat/s0_d/s0_v  out  20/6/2/2/1/1  selected-page fields
s1_vppn, s1_va_bit12, s1_asid, s1_found, s1_index, s1_ppn..s1_v  same as s0; data port
invtlb_valid  in  1  perform INVTLB this cycle
invtlb_op  in  5  INVTLB op code; ASID/VA taken from s1_asid/s1_vppn
we  in  1  write enable (TLBWR/TLBFILL)
w_index  in  LOG2TLBNUM  write slot
w_e/w_vppn/w_ps/w_asid/w_g  in  1/19/6/10/1  entry header
w_ppn0/w_plv0/w_mat0/w_d0/w_v0  in  20/2/2/1/1  even page
w_ppn1/w_plv1/w_mat1/w_d1/w_v1  in  20/2/2/1/1  odd page
r_index  in  LOG2TLBNUM  read slot (TLBRD)
r_e/r_vppn/r_ps/r_asid/r_g/r_ppn0..r_v1  out  same widths as w_*  entry contents

Behaviour:
- Interface: one clock `clk`. `reset` is asynchronous and active-high.
- Storage: per entry e, vppn, ps, asid, g, and two page records {ppn, plv, mat, d, v}.
- Reset: all fields of every entry are cleared to 0 immediately, without waiting for a clock edge.
- Outputs during/after reset: all found=0; all search and read outputs are 0.
- Search (combinational, 0-cycle latency): entry i matches when all of:
  - e=1;
  - g=1 or asid==s_asid;
  - if ps==12: vppn==s_vppn; otherwise (ps==21): vppn[18:9]==s_vppn[18:9].
- Page select: odd page when (ps==12 ? s_va_bit12 : s_vppn[8]); otherwise even page.
- found is the OR of all matches. On multiple hits, the lowest index wins; index and fields come from that entry.
- No hit: index=0 and all field outputs are 0.
- Read (combinational): r_* equal the contents of entry r_index, including when e=0.
- Write: at posedge clk with we=1, every field of entry w_index is replaced. The new value is visible to search/read in the following cycle.
- INVTLB: at posedge clk with invtlb_valid=1, e is cleared (other fields untouched) on every entry satisfying:
  - op 0 or 1: all entries;
  - op 2: g=1;
  - op 3: g=0;
  - op 4: g=0 and asid==s1_asid;
  - op 5: g=0, asid==s1_asid, and VA match (ps-aware, as in search);
  - op 6: (g=1 or asid==s1_asid) and VA match.
- op>6: no state change. The pipeline raises INE for such ops; this block ignores them.
- Simultaneous we and invtlb_valid in the same cycle: invalidation applies first, then the write. The written entry ends with w_e regardless of the INVTLB match.
- Reset asserted mid-write or mid-INVTLB: reset dominates; the entry stays cleared.
- Index arithmetic: w_index and r_index are always in range when TLBNUM==2^LOG2TLBNUM. No wrap logic is required.

Test Plan:
- Reset, then read all 16 slots -> r_e=0 and all fields 0; s0_found=s1_found=0 for any input.
- Write idx 5 {e=1, vppn=0x12345, ps=12, asid=0x3, g=0, ppn1=0xABCDE, v1=1}; search s0 with vppn=0x12345, bit12=1, asid=3 -> found=1, index=5, ppn=0xABCDE, v=1. Same search with asid=4 -> found=0.
- Write idx 2 {ps=21, vppn=0x40000, g=1, ppn0=0x111}; search s1 with vppn=0x400FF, s_vppn[8]=0, any asid -> hit idx 2, ppn=0x111. Search with s_vppn[8]=1 -> odd page selected.
- Entries 1 and 9 both match the same VA -> index=1.
- INVTLB op 4, s1_asid=3, with idx5 (g=0, asid 3) and idx2 (g=1) valid -> idx5 e=0, idx2 unchanged. Op 2 -> idx2 cleared. Op 7 -> no change.
- In the same cycle, we to idx5 with w_e=1 and INVTLB op 0 -> afterwards only idx5 valid. Assert reset between clock edges -> found drops to 0 immediately.
